// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control for load-use, branch-on-load, mul/div occupancy and cache freezes
// Optional feature macro: HAZARD_PERF_EN builds the three stall performance counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   RsD, RtD                      source registers of the instruction in D
//   WriteRegE, WriteRegM          destination registers in E and M
//   RegWriteE                     reserved, no effect on outputs
//   MemtoRegE, MemtoRegM          E/M instruction is a load
//   BranchD                       D holds a branch/jr resolving in D
//   MulDivE                       E holds a multi-cycle mul/div op
//   ICacheStall, DCacheStall      cache miss in progress
//   StallF..StallW                hold the stage register
//   FlushE, FlushM                load a bubble into the stage register
//   StallCntLU/MD/Mem             stall-cycle counters (zero unless HAZARD_PERF_EN)
module hazard_unit #(
   parameter int MD_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [4:0]  WriteRegE,
   input  logic [4:0]  WriteRegM,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        BranchD,
   input  logic        MulDivE,
   input  logic        ICacheStall,
   input  logic        DCacheStall,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        StallW,
   output logic        FlushE,
   output logic        FlushM,
   output logic [31:0] StallCntLU,
   output logic [31:0] StallCntMD,
   output logic [31:0] StallCntMem
);
   typedef enum logic {RUN, MD_BUSY} stateT;
   stateT state, stateNext;
   logic [7:0] cnt, cntNext;
   logic lwHit, brHit, mem, mdStall, hz, unusedRegWriteE;
   assign unusedRegWriteE = RegWriteE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt <= '0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
      end
   end
   always_comb begin
      lwHit = MemtoRegE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD);
      brHit = BranchD && MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD);
      mem = ICacheStall || DCacheStall;
      mdStall = (state == RUN && MulDivE) || (state == MD_BUSY && cnt > 8'd1);
      hz = lwHit || brHit;
      stateNext = state;
      cntNext = cnt;
      // the divider keeps counting through a freeze; only the final release waits for mem to drop
      if (state == RUN) begin
         if (MulDivE && !mem) begin
            stateNext = MD_BUSY;
            cntNext = 8'(MD_LAT - 1);
         end
      end else if (cnt > 8'd1)
         cntNext = cnt - 8'd1;
      else if (!mem) begin
         stateNext = RUN;
         cntNext = '0;
      end
   end
   assign StallF = mem || mdStall || hz;
   assign StallD = StallF;
   assign StallE = mem || mdStall;
   assign StallM = mem;
   assign StallW = mem;
   assign FlushE = !mem && !mdStall && hz;
   assign FlushM = !mem && mdStall;
`ifdef HAZARD_PERF_EN
   logic [31:0] cntLU, cntMD, cntMem;
   always_ff @(posedge clk) begin
      if (rst) begin
         cntLU <= '0;
         cntMD <= '0;
         cntMem <= '0;
      end else begin
         cntLU <= cntLU + 32'(FlushE);
         cntMD <= cntMD + 32'(FlushM);
         cntMem <= cntMem + 32'(mem);
      end
   end
   assign StallCntLU = cntLU;
   assign StallCntMD = cntMD;
   assign StallCntMem = cntMem;
`else
   assign StallCntLU = '0;
   assign StallCntMD = '0;
   assign StallCntMem = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against a cycle-level reference model
module tb_hazard_unit;
   localparam int LAT = 4;
   logic clk = 0, rst = 1;
   logic [4:0] RsD = 0, RtD = 0, WriteRegE = 0, WriteRegM = 0;
   logic RegWriteE = 0, MemtoRegE = 0, MemtoRegM = 0, BranchD = 0, MulDivE = 0;
   logic ICacheStall = 0, DCacheStall = 0;
   logic StallF, StallD, StallE, StallM, StallW, FlushE, FlushM;
   logic [31:0] StallCntLU, StallCntMD, StallCntMem;
   int nCmp = 0, nFail = 0;
   // reference model: whether a mul/div op has been accepted and how many cycles since acceptance
   bit active = 0;
   int age = 0;
   logic [31:0] mLU = 0, mMD = 0, mMem = 0;

   hazard_unit #(.MD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MulDivE(MulDivE), .ICacheStall(ICacheStall), .DCacheStall(DCacheStall),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushE(FlushE), .FlushM(FlushM),
      .StallCntLU(StallCntLU), .StallCntMD(StallCntMD), .StallCntMem(StallCntMem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one cycle: check outputs mid-cycle, then advance the model at the clock edge
   task automatic cycle(input string tag);
      bit mem, mds, lw, br;
      logic [6:0] exp;
      int rule;
      mem = ICacheStall | DCacheStall;
      mds = active ? (age <= LAT - 2) : MulDivE;
      lw = MemtoRegE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
      br = BranchD && MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD);
      rule = mem ? 1 : mds ? 2 : (lw || br) ? 3 : 4;
      // order {F,D,E,M,W,FlushE,FlushM}
      exp = rule == 1 ? 7'b1111100 : rule == 2 ? 7'b1110001 : rule == 3 ? 7'b1100010 : 7'b0;
      @(negedge clk);
      chk({tag, ".ctl"}, 32'({StallF, StallD, StallE, StallM, StallW, FlushE, FlushM}), 32'(exp));
`ifdef HAZARD_PERF_EN
      chk({tag, ".cLU"}, StallCntLU, mLU);
      chk({tag, ".cMD"}, StallCntMD, mMD);
      chk({tag, ".cMem"}, StallCntMem, mMem);
`else
      chk({tag, ".cnt"}, StallCntLU | StallCntMD | StallCntMem, 32'd0);
`endif
      @(posedge clk);
      if (rst) begin
         active = 0; age = 0; mLU = 0; mMD = 0; mMem = 0;
      end else begin
         mLU += 32'(rule == 3);
         mMD += 32'(rule == 2);
         mMem += 32'(rule == 1);
         if (!active) begin
            if (MulDivE && !mem) begin active = 1; age = 1; end
         end else if (age >= LAT - 1 && !mem) begin
            active = 0; age = 0;
         end else age++;
      end
      #1;
   endtask

   task automatic idle();
      rst = 0; RsD = 0; RtD = 0; WriteRegE = 0; WriteRegM = 0; MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; MulDivE = 0; ICacheStall = 0; DCacheStall = 0; RegWriteE = 0;
   endtask

   initial begin
      @(posedge clk); #1;
      cycle("reset");
      idle();
      cycle("idle");
      MemtoRegE = 1; WriteRegE = 8; RsD = 8;
      cycle("loaduse");
      WriteRegE = 0;
      cycle("loaduse_r0");
      idle();
      cycle("after_lu");
      MulDivE = 1;
      for (int i = 0; i < LAT; i++) cycle("md");
      MulDivE = 0;
      cycle("md_done");
      MulDivE = 1;
      for (int i = 0; i < LAT + 4; i++) begin
         DCacheStall = (i >= 2 && i <= 5);
         cycle("md_dmiss");
      end
      idle();
      cycle("md_dmiss_done");
      BranchD = 1; MemtoRegM = 1; WriteRegM = 5; RtD = 5; ICacheStall = 1;
      cycle("br_imiss");
      ICacheStall = 0;
      cycle("br_after");
      idle();
      MemtoRegE = 1; WriteRegE = 3; RtD = 3; DCacheStall = 1;
      cycle("lu_mem");
      DCacheStall = 0;
      cycle("lu_after_mem");
      idle();
      MulDivE = 1;
      cycle("rst_c0");
      rst = 1;
      cycle("rst_c1");
      idle();
      cycle("rst_c2");
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         RsD = 5'($urandom_range(0, 3));
         RtD = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom);
         MemtoRegE = 1'($urandom);
         MemtoRegM = 1'($urandom);
         BranchD = 1'($urandom);
         MulDivE = ($urandom_range(0, 5) == 0);
         ICacheStall = ($urandom_range(0, 7) == 0);
         DCacheStall = ($urandom_range(0, 7) == 0);
         cycle("rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core; it sits alongside the forwarding unit in the decode/execute region. It consumes the same register-address and write-enable fields the forwarding unit uses and produces per-stage stall and flush controls. Hazards it covers:
- Load-use and branch-on-load hazards.
- Multi-cycle multiply/divide occupancy of the E stage, tracked with an internal busy counter.
- I-cache and D-cache miss freezes.

## Interface
Parameters:
- `MD_LAT`, default 4: total cycles a multi-cycle mul/div op occupies E. Legal range 2..255.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `RsD`, `RtD` in 5 each: source registers of the instruction in D.
- `WriteRegE`, `WriteRegM` in 5 each: destination registers in E and M.
- `RegWriteE` in 1: E-stage write enable. Reserved; has no effect on any output.
- `MemtoRegE`, `MemtoRegM` in 1 each: E/M instruction is a load.
- `BranchD` in 1: D holds a branch or `jr` that resolves in D.
- `MulDivE` in 1: E holds a multi-cycle mul/div op.
- `ICacheStall`, `DCacheStall` in 1 each: cache miss in progress.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW` out 1 each: hold the stage register.
- `FlushE`, `FlushM` out 1 each: load a bubble into the stage register.
- `StallCntLU`, `StallCntMD`, `StallCntMem` out 32 each: performance counters (see Configuration).

## Operation
Registered state:
- `state`: RUN or MD_BUSY.
- `cnt[7:0]`: mul/div busy counter.
- Three perf counters.

Hazard terms (combinational):
- `lw_hit = MemtoRegE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD)`.
- `br_hit = BranchD & MemtoRegM & WriteRegM!=0 & (WriteRegM==RsD | WriteRegM==RtD)`.
- `mem = ICacheStall | DCacheStall`.
- `md_stall = (state==RUN & MulDivE) | (state==MD_BUSY & cnt>1)`.

Output priority, first match wins:
1. `mem`: all five Stall outputs = 1; `FlushE` = `FlushM` = 0.
2. `md_stall`: `StallF`, `StallD`, `StallE` = 1; `FlushM` = 1; others 0.
3. `lw_hit | br_hit`: `StallF`, `StallD` = 1; `FlushE` = 1; others 0.
4. Otherwise all outputs 0.

`lw_hit` and `br_hit` are masked while `md_stall` or `mem` is active. They are re-evaluated every cycle; nothing is latched.

FSM:
- RUN -> MD_BUSY when `MulDivE & !mem`, loading `cnt = MD_LAT-1`. With `mem` asserted, stay in RUN; the op is not yet accepted.
- MD_BUSY: `cnt` decrements each cycle while `cnt>1`. It keeps decrementing during `mem`, because the divider runs independently.
- In MD_BUSY with `cnt==1`, `cnt` holds at 1 while `mem` is asserted.
- MD_BUSY -> RUN on a cycle with `cnt==1 & !mem`. This is the release cycle: no MD stall, and E advances at the end of that cycle.

Reset: `state` = RUN, `cnt` = 0, all perf counters 0, all outputs 0 (given deasserted inputs). Asserting `rst` mid-MD_BUSY abandons the op; the next cycle is RUN.

## Timing
- All Stall and Flush outputs are combinational from inputs plus registered state, so they are valid in the same cycle the hazard is presented.
- A mul/div op entering E in cycle C0 with no `mem` is stalled in C0..C0+MD_LAT-2 and released in C0+MD_LAT-1. It occupies E for exactly MD_LAT cycles.
- Each cycle of `mem` overlapping the release extends occupancy by one cycle.
- Load-use costs exactly one bubble cycle.
- Branch-on-load-in-M costs one stall cycle.
- A branch on a load in E costs two cycles: one for `lw_hit`, then one for `br_hit`.
- `mem` asserted in the same cycle as `lw_hit` freezes everything. `FlushE` fires on the first cycle after `mem` drops, provided the hazard is still present.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `StallCntLU` increments on each cycle where rule 3 drives outputs.
  - `StallCntMD` increments on each rule-2 cycle.
  - `StallCntMem` increments on each rule-1 cycle.
  - Counters are 32-bit, wrap modulo 2^32, and clear on `rst`.
- Undefined: the counter registers are not built and the three ports are tied to 0. All other behaviour is identical.

## Test plan
- `MemtoRegE`=1, `WriteRegE`=8, `RsD`=8 for one cycle -> `StallF`=`StallD`=`FlushE`=1 that cycle; `StallCntLU`=1 with `HAZARD_PERF_EN`.
- Same as above with `WriteRegE`=0 -> all outputs 0.
- `MD_LAT`=4, `MulDivE`=1 at C0 -> `StallE`=1 and `FlushM`=1 in C0..C2; all outputs 0 in C3; `state` returns to RUN.
- `MD_LAT`=4, `MulDivE` at C0, `DCacheStall` high C2..C5 -> all five stalls high C2..C5; `cnt` holds at 1; release in C6.
- `BranchD`=1, `MemtoRegM`=1, `WriteRegM`=5, `RtD`=5, `ICacheStall`=1 -> rule 1 only (`FlushE`=0); after `ICacheStall` drops -> `StallD`=1, `FlushE`=1.
- `rst` asserted at C1 of an `MD_LAT`=8 op -> in C2 `state`=RUN, all stalls 0, perf counters 0.
